// File: rtl/seven_seg_display_ctrl.sv
// seven_seg_display_ctrl
//   Multi-digit 7-segment display controller for the queue ticket display.
//   A binary value is accepted over a valid/ready handshake, converted to BCD
//   one bit per clock (double-dabble), then latched as NUM_DIGITS registered
//   segment patterns with optional leading-zero blanking and an overflow
//   indication (every digit shows '-').
//
//   Optional feature macro: SEG_BLINK_EN
//     defined   -> free-running blink counter/phase; while blink=1 and the
//                  phase is 1 the output port shows all segments off.
//     undefined -> blink is ignored and seg_out follows the register.
//
// Ports
//   clk          in   rising-edge system clock
//   rst_n        in   asynchronous active-low reset
//   in_valid     in   in_value/blank_zeros valid
//   in_ready     out  controller idle, can accept
//   in_value     in   [BIN_W] unsigned binary value to display
//   blank_zeros  in   blank leading zeros of this value
//   blink        in   request display blink (SEG_BLINK_EN only)
//   done         out  1-cycle pulse: seg_out updated
//   seg_out      out  [7*NUM_DIGITS] digit i at [7*i+6:7*i], order {a..g}
module seven_seg_display_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_W      = 14,
  parameter int ACTIVE_LOW = 1,
  parameter int BLINK_DIV  = 25_000_000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BIN_W-1:0]        in_value,
  input  logic                    blank_zeros,
  input  logic                    blink,
  output logic                    done,
  output logic [7*NUM_DIGITS-1:0] seg_out
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int SEG_W = 7 * NUM_DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [31:0] MAX_VAL = 32'(10 ** NUM_DIGITS - 1);
  localparam logic [SEG_W-1:0] SEG_OFF = (ACTIVE_LOW != 0) ? {SEG_W{1'b1}} : {SEG_W{1'b0}};

  typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_t;

  state_t            state_q, state_d;
  logic [BIN_W-1:0]  bin_q, bin_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic [BCD_W-1:0]  bcd_adj;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              blank_q, blank_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;
  logic [SEG_W-1:0]  seg_q, seg_d, seg_new;
  logic [6:0]        pat;
  logic              higher_zero;
  logic              accept;
  logic              unused_bcd_msb;

  // Active-high segment pattern {a,b,c,d,e,f,g} for one BCD digit.
  function automatic logic [6:0] enc(input logic [3:0] n);
    case (n)
      4'd0: enc = 7'h7E;
      4'd1: enc = 7'h30;
      4'd2: enc = 7'h6D;
      4'd3: enc = 7'h79;
      4'd4: enc = 7'h33;
      4'd5: enc = 7'h5B;
      4'd6: enc = 7'h5F;
      4'd7: enc = 7'h70;
      4'd8: enc = 7'h7F;
      4'd9: enc = 7'h7B;
      default: enc = 7'h00;
    endcase
  endfunction

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // The last iteration happens on the edge where cnt_q is 1.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = CONVERT;
      CONVERT: if (cnt_q == CNT_W'(1)) state_d = UPDATE;
      UPDATE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == IDLE);
  end

  // Double-dabble step: add 3 to every nibble >= 5, then shift {bcd,bin} left.
  // The bit leaving the top nibble is dropped; overflow is flagged separately.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  assign unused_bcd_msb = bcd_adj[BCD_W-1];

  always_comb begin
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    blank_d = blank_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          bin_d   = in_value;
          bcd_d   = '0;
          cnt_d   = CNT_W'(BIN_W);
          blank_d = blank_zeros;
          ovf_d   = ({{(32-BIN_W){1'b0}}, in_value} > MAX_VAL);
        end
      end
      CONVERT: begin
        bcd_d = {bcd_adj[BCD_W-2:0], bin_q[BIN_W-1]};
        bin_d = bin_q << 1;
        cnt_d = cnt_q - CNT_W'(1);
      end
      default: ;
    endcase
  end

  // Walk digits from the most significant down; a digit is blanked only while
  // every digit above it (and itself) is zero, and digit 0 is never blanked.
  always_comb begin
    seg_new     = SEG_OFF;
    pat         = 7'h00;
    higher_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (bcd_q[4*i +: 4] != 4'd0) higher_zero = 1'b0;
      pat = enc(bcd_q[4*i +: 4]);
      if (blank_q && higher_zero && (i != 0)) pat = 7'h00;
      if (ovf_q) pat = 7'h01;
      seg_new[7*i +: 7] = (ACTIVE_LOW != 0) ? ~pat : pat;
    end
  end

  always_comb begin
    done_d = (state_q == UPDATE);
    seg_d  = (state_q == UPDATE) ? seg_new : seg_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      blank_q <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      seg_q   <= SEG_OFF;
    end else begin
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      blank_q <= blank_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      seg_q   <= seg_d;
    end
  end

  assign done = done_q;

`ifdef SEG_BLINK_EN
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               phase_q, phase_d;

  // Phase toggles each time the free-running counter wraps.
  always_comb begin
    blink_cnt_d = blink_cnt_q + BLINK_W'(1);
    phase_d     = phase_q;
    if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  // Blanking is applied at the port only; seg_q keeps the displayed value.
  assign seg_out = (blink && phase_q) ? SEG_OFF : seg_q;
`else
  logic unused_blink;
  assign unused_blink = blink ^ (BLINK_DIV > 0);
  assign seg_out      = seg_q;
`endif

endmodule
